// File: rtl/dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_if : request/response bundle between MEM stage and dmem_responder |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface dmem_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;
  logic            req_read;
  logic [1:0]      req_load_type;
  logic            req_unsigned;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_error;

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, req_read,
           req_load_type, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, req_read,
           req_load_type, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : multi-cycle data memory with byte steering/extension |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int                 c_cnt_w    = 4;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
  localparam int                 c_aw       = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_aw-1:0]     r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_read;
  logic [1:0]          r_load_type;
  logic                r_unsigned;
  logic [XLEN-1:0]     r_rdata;
  logic                r_error;
  logic [XLEN-1:0]     r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_strb_legal;
  logic                  w_is_half;
  logic                  w_is_word;
  logic                  w_req_error;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [3:0]            w_lane_mask;
  logic [XLEN-1:0]       w_wdata_sh;
  logic [XLEN-1:0]       w_rd_word;
  logic [XLEN-1:0]       w_rd_sh;
  logic [XLEN-1:0]       w_load_data;

  // Request legality is judged on the live inputs in the accept cycle.
  always_comb begin
    w_strb_legal = (bus.req_wstrb == 4'b0000) || (bus.req_wstrb == 4'b0001) ||
                   (bus.req_wstrb == 4'b0011) || (bus.req_wstrb == 4'b1111);
    w_is_half    = bus.req_read ? (bus.req_load_type == 2'b01) : (bus.req_wstrb == 4'b0011);
    w_is_word    = bus.req_read ? bus.req_load_type[1]        : (bus.req_wstrb == 4'b1111);
    w_req_error  = (bus.req_read && (bus.req_wstrb != 4'b0000)) || !w_strb_legal ||
                   (w_is_half && bus.req_addr[0]) ||
                   (w_is_word && (bus.req_addr[1:0] != 2'b00));
  end

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) w_next = w_req_error ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_index     = r_addr[ADDR_WIDTH+1:2];
  assign w_lane_mask = r_wstrb << r_addr[1:0];
  assign w_wdata_sh  = r_wdata << {r_addr[1:0], 3'b000};
  assign w_rd_word   = r_mem[w_index];
  assign w_rd_sh     = w_rd_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = w_rd_sh;
    case (r_load_type)
      2'b00:   w_load_data = {{(XLEN-8){!r_unsigned && w_rd_sh[7]}}, w_rd_sh[7:0]};
      2'b01:   w_load_data = {{(XLEN-16){!r_unsigned && w_rd_sh[15]}}, w_rd_sh[15:0]};
      default: w_load_data = w_rd_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_read      <= 1'b0;
      r_load_type <= 2'b00;
      r_unsigned  <= 1'b0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= bus.req_addr[c_aw-1:0];
        r_wdata     <= bus.req_wdata;
        r_wstrb     <= bus.req_wstrb;
        r_read      <= bus.req_read;
        r_load_type <= bus.req_load_type;
        r_unsigned  <= bus.req_unsigned;
        if (w_req_error) begin
          r_error <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_cnt <= c_cnt_load;
        end
      end
      if (r_state == S_WAIT) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_error <= 1'b0;
          r_rdata <= r_read ? w_load_data : '0;
        end
      end
    end
  end

  // Storage is not reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && !r_read) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_mask[b]) r_mem[w_index][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench with byte-level memory model     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_if #(.XLEN(32)) bus();

  dmem_responder #(.XLEN(32), .ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] mb [0:4095];
  bit         hold     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte-addressed model of a 4 KB space; addresses wrap at 4 KB.
  task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input bit read, input logic [1:0] lt, input bit uns,
                       output logic [31:0] d, output logic err);
    int n;
    logic [11:0] ba;
    err = 1'b0;
    d   = 32'h0;
    if (read && wstrb != 4'h0) err = 1'b1;
    if (!(wstrb == 4'h0 || wstrb == 4'h1 || wstrb == 4'h3 || wstrb == 4'hF)) err = 1'b1;
    if (read) n = (lt == 2'd0) ? 1 : (lt == 2'd1) ? 2 : 4;
    else      n = (wstrb == 4'h1) ? 1 : (wstrb == 4'h3) ? 2 : (wstrb == 4'hF) ? 4 : 0;
    if (n == 2 && addr[0]) err = 1'b1;
    if (n == 4 && addr[1:0] != 2'b00) err = 1'b1;
    if (err) return;
    ba = addr[11:0];
    if (read) begin
      for (int b = 0; b < n; b++) d = d | (32'(mb[int'(ba) + b]) << (8 * b));
      if (!uns && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
    end else begin
      for (int b = 0; b < n; b++) mb[int'(ba) + b] = wdata[8*b +: 8];
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input bit read, input logic [1:0] lt, input bit uns,
                       input bit expect_rsp, input bit has_exp, input logic [31:0] exp_val);
    exp_t e;
    logic [31:0] d;
    logic err;
    int n;
    @(negedge clk);
    bus.req_addr      = addr;
    bus.req_wdata     = wdata;
    bus.req_wstrb     = wstrb;
    bus.req_read      = read;
    bus.req_load_type = lt;
    bus.req_unsigned  = uns;
    bus.req_valid     = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high addr=%h", addr);
      bus.req_valid = 1'b0;
    end else begin
      if (expect_rsp) begin
        model(addr, wdata, wstrb, read, lt, uns, d, err);
        if (has_exp) d = exp_val;
        e.data = d;
        e.err  = err;
        e.due  = cyc + 1 + (err ? 0 : LAT);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    issue(a, w, s, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] lt, input bit u, input logic [31:0] x);
    issue(a, 32'h0, 4'h0, 1'b1, lt, u, 1'b1, 1'b1, x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=rsp_valid required=no_response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.data);
        chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2, addr, wdata;
    logic [3:0]  wstrb;
    bit          read, uns;
    logic [1:0]  lt;
    int          k;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.req_read = 1'b0; bus.req_load_type = '0; bus.req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) st(32'(i * 4), $urandom, 4'hF);

    st(32'h40, 32'hDEADBEEF, 4'hF);
    ld(32'h40, 2'd2, 1'b0, 32'hDEADBEEF);
    st(32'h41, 32'h00000080, 4'h1);
    ld(32'h41, 2'd0, 1'b0, 32'hFFFFFF80);
    ld(32'h41, 2'd0, 1'b1, 32'h00000080);
    ld(32'h40, 2'd2, 1'b0, 32'hDEAD80EF);
    st(32'h42, 32'h00008001, 4'h3);
    ld(32'h42, 2'd1, 1'b0, 32'hFFFF8001);
    ld(32'h42, 2'd1, 1'b1, 32'h00008001);
    ld(32'h40, 2'd2, 1'b0, 32'h800180EF);
    ld(32'h41, 2'd2, 1'b0, 32'h0);
    st(32'h43, 32'h0000FFFF, 4'h3);
    ld(32'h40, 2'd2, 1'b0, 32'h800180EF);
    st(32'h1000, 32'hCAFEF00D, 4'hF);
    ld(32'h0000, 2'd2, 1'b0, 32'hCAFEF00D);

    // Store dropped by a reset one cycle after it is accepted.
    st(32'h80, 32'h0, 4'hF);
    ld(32'h40, 2'd2, 1'b0, 32'h800180EF);
    drain();
    issue(32'h80, 32'h12345678, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midwait_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midwait_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("midwait_rsp_error", 32'(bus.rsp_error), 32'd0);
    reset = 1'b0;
    ld(32'h80, 2'd2, 1'b0, 32'h0);
    drain();

    // Request presented together with reset must not be taken.
    @(negedge clk);
    reset = 1'b1;
    bus.req_addr = 32'h84; bus.req_wdata = 32'hA5A5A5A5; bus.req_wstrb = 4'hF;
    bus.req_read = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    chk("reset_accept_ready", 32'(bus.req_ready), 32'd1);
    issue(32'h84, 32'h0, 4'h0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      if (i == 100) hold = 1'b1;
      if (i == 200) hold = 1'b0;
      r1 = $urandom;
      r2 = $urandom;
      addr  = {r1[31:12], 4'h0, r2[7:0]};
      wdata = $urandom;
      read  = 1'b0;
      wstrb = 4'h0;
      lt    = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      k     = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: read = 1'b1;
        4:       wstrb = 4'h1;
        5:       wstrb = 4'h3;
        6:       wstrb = 4'hF;
        7:       wstrb = 4'h0;
        8:       wstrb = 4'($urandom_range(0, 15));
        default: begin read = 1'b1; wstrb = 4'($urandom_range(1, 15)); end
      endcase
      issue(addr, wdata, wstrb, read, lt, uns, 1'b1, 1'b0, 32'h0);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services load/store requests issued by the MEM stage of the pipelined core. It replaces the single-cycle data memory with a valid/ready request port and a one-cycle response pulse, with configurable access latency. It also performs byte-lane steering, sign/zero extension and misalignment detection. The MEM stage holds its request and stalls the pipeline while `req_ready` is low.

## Interface
- `XLEN`, 32: data/address width.
- `ADDR_WIDTH`, 10: word-address bits; storage is 2^ADDR_WIDTH words of XLEN bits.
- `LATENCY`, 2: wait cycles before the access commits; legal values are 1..15.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request. High only in IDLE.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, unshifted. A byte is in [7:0] and a half in [15:0].
- `req_wstrb` in 4: store size, unshifted. Legal values are 0000, 0001 (SB), 0011 (SH) and 1111 (SW).
- `req_read` in 1: load request.
- `req_load_type` in 2: 00 byte, 01 half, 10 word. 11 is treated as word.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU). Ignored for word loads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out XLEN: load result, valid while `rsp_valid`. Holds its value until the next response.
- `rsp_error` out 1: misaligned or illegal request, valid while `rsp_valid`.

## Operation
- **Reset.** The state goes to IDLE.
  - Reset output values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, wait counter = 0.
  - Storage contents are not reset.
- **IDLE.** On `req_valid`&&`req_ready` the block captures addr, wdata, wstrb, read, load_type and unsigned. It then checks the request:
  - *Error* if any of the following holds; the next state is RESP:
    - `req_read` and `req_wstrb`!=0 are both set;
    - `req_wstrb` is not one of the four legal values;
    - a half access has addr[0]=1;
    - a word access has addr[1:0]!=0.
  - *Otherwise* the next state is WAIT and the counter loads LATENCY-1.
- **WAIT.**
  - While the counter is nonzero it decrements.
  - When the counter is 0, the access commits on that edge and the next state is RESP.
  - Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
  - *Store:* byte lane mask = wstrb << addr[1:0]. Data = wdata << (8*addr[1:0]). Only masked bytes are written.
  - *Load:* the word is read and shifted right by 8*addr[1:0]. The result is then sign- or zero-extended from bit 7 (byte), from bit 15 (half), or passed through (word). This value is registered into `rsp_rdata`.
  - *No-op* (read=0, wstrb=0): nothing is written and `rsp_rdata` is set to 0.
- **RESP.** `rsp_valid`=1 for exactly one cycle and the next state is IDLE.
  - On error: `rsp_error`=1, `rsp_rdata`=0, and storage is untouched.
  - For a store: `rsp_rdata`=0.
- **No response backpressure.** The requester must sample `rsp_valid` when it pulses.
- **Requests outside IDLE.** `req_valid` is ignored outside IDLE. Request inputs may change freely once the request has been accepted.

## Timing
- Accept edge at the end of cycle T.
- Aligned request:
  - WAIT occupies cycles T+1..T+LATENCY and the commit happens at the end of T+LATENCY.
  - `rsp_valid` is high in cycle T+LATENCY+1.
  - `req_ready` goes high again in cycle T+LATENCY+2.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- Error request: `rsp_valid` is high in T+1 and `req_ready` is high in T+2.
- `req_ready` is low from T+1 until the cycle after RESP.
- Reset mid-operation: the block returns to IDLE with the reset output values. A store not yet committed is dropped; a committed store persists.
- Reset in the same cycle as `req_valid`: the request is not accepted.
- A load that follows a store to the same word returns the stored data, because the store commits before the load is accepted.

## Test plan
- **LATENCY=2 word store/load.** SW 0xDEADBEEF to addr 0x40, then LW from 0x40.
  - `rsp_valid` for the store arrives 3 cycles after accept with `rsp_rdata`=0.
  - The load returns 0xDEADBEEF with `rsp_error`=0.
- **Byte lanes.** SB 0x80 to 0x41, then LB from 0x41 → 0xFFFFFF80; LBU from 0x41 → 0x00000080; LW from 0x40 → 0xDEAD80EF.
- **Halves.** SH 0x8001 to 0x42, then LH from 0x42 → 0xFFFF8001; LHU → 0x00008001; LW from 0x40 → 0x800180EF.
- **Misaligned.**
  - LW from 0x41 → `rsp_valid` at T+1 with `rsp_error`=1 and `rsp_rdata`=0.
  - SH to 0x43 → `rsp_error`=1, and a subsequent LW from 0x40 is unchanged.
- **Reset mid-WAIT.** Assert `reset` one cycle after accepting SW 0x12345678 to 0x80.
  - Outputs return to reset values and `req_ready`=1.
  - Pre-load 0x80 with 0 before the SW; after the reset, LW from 0x80 ≠ 0x12345678 (returns 0).
- **Handshake and wrap.**
  - Hold `req_valid` high continuously: requests are accepted only when `req_ready`=1, with exactly one `rsp_valid` per accept.
  - SW to 0x1000 followed by LW from 0x0000 (ADDR_WIDTH=10) returns the same data.
